// File: rtl/uart_tx_frame_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_frame_if
// Purpose  : Byte handshake between the user/FIFO side and uart_tx_frame.
//            master drives data/valid, slave (the transmitter) drives ready.
// Revision : 1.0 - initial release
// ============================================================================
interface uart_tx_frame_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface
`default_nettype wire

// File: rtl/uart_tx_frame.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_frame
// Purpose  : Byte-serialising UART transmitter. Frames one byte as start,
//            LSB-first data, optional even parity and stop bit(s); every
//            bit lasts one i_baud_en period. TXD and TX_DONE are registered.
// Options  : define UART_TX_PARITY_EN to add an even-parity bit per frame.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_frame #(
  parameter int DATA_BITS = 8,   // 5..8
  parameter int STOP_BITS = 1    // 1 or 2
) (
  input  wire logic      clk,
  input  wire logic      rst,
  input  wire logic      i_baud_en,
  uart_tx_frame_if.slave tx_if,
  output logic           o_txd,
  output logic           o_tx_busy,
  output logic           o_tx_done
);

  localparam logic [3:0] C_LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0] C_LAST_STOP = 4'(STOP_BITS - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SYNC   = 3'd1,
    S_START  = 3'd2,
    S_DATA   = 3'd3,
    S_PARITY = 3'd4,
    S_STOP   = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SYNC   = 3'd1,
    S_START  = 3'd2,
    S_DATA   = 3'd3,
    S_STOP   = 3'd5
  } state_t;
`endif

  state_t               state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [3:0]           cnt_q, cnt_d;
  logic                 txd_q, txd_d;
  logic                 done_q, done_d;
`ifdef UART_TX_PARITY_EN
  logic                 parity_q, parity_d;
`endif

  // Next-state, datapath and next-TXD computation; TXD is derived from the
  // next state so the registered line changes on the same edge as the state.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      S_IDLE: begin
        // A tick coincident with the transfer is deliberately ignored: the
        // frame waits in SYNC so the start bit is always full length.
        if (tx_if.tx_valid) begin
          state_d = S_SYNC;
          shift_d = tx_if.tx_data;
          cnt_d   = 4'd0;
`ifdef UART_TX_PARITY_EN
          parity_d = ^tx_if.tx_data;
`endif
        end
      end
      S_SYNC: begin
        if (i_baud_en) state_d = S_START;
      end
      S_START: begin
        if (i_baud_en) begin
          state_d = S_DATA;
          cnt_d   = 4'd0;
        end
      end
      S_DATA: begin
        if (i_baud_en) begin
          shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
          if (cnt_q == C_LAST_DATA) begin
            cnt_d = 4'd0;
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (i_baud_en) begin
          state_d = S_STOP;
          cnt_d   = 4'd0;
        end
      end
`endif
      S_STOP: begin
        // Counter reused to time one or two stop bits.
        if (i_baud_en) begin
          if (cnt_q == C_LAST_STOP) begin
            state_d = S_IDLE;
            cnt_d   = 4'd0;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase

    case (state_d)
      S_START: txd_d = 1'b0;
      S_DATA:  txd_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: txd_d = parity_d;
`endif
      default: txd_d = 1'b1;
    endcase
  end

  // State and output registers; reset forces the line idle immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      shift_q  <= '0;
      cnt_q    <= 4'd0;
      txd_q    <= 1'b1;
      done_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      cnt_q    <= cnt_d;
      txd_q    <= txd_d;
      done_q   <= done_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign tx_if.tx_ready = (state_q == S_IDLE);
  assign o_tx_busy      = (state_q != S_IDLE);
  assign o_txd          = txd_q;
  assign o_tx_done      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_frame.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_frame
// Purpose  : Directed self-checking bench for uart_tx_frame (8N1 default,
//            8E1 when UART_TX_PARITY_EN is defined).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_uart_tx_frame;

  localparam int DB = 8;
  localparam int SB = 1;
`ifdef UART_TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int NB    = 1 + DB + PB + SB;
  localparam int LIMIT = 400;

  logic clk     = 1'b0;
  logic rst     = 1'b1;
  logic baud_en = 1'b0;
  logic txd, busy, done;
  bit   stuck    = 1'b0;
  int   bcnt     = 0;
  int   total    = 0;
  int   bad      = 0;
  int   done_cnt = 0;

  uart_tx_frame_if #(.DATA_BITS(DB)) bus ();

  uart_tx_frame #(.DATA_BITS(DB), .STOP_BITS(SB)) dut (
    .clk       (clk),
    .rst       (rst),
    .i_baud_en (baud_en),
    .tx_if     (bus),
    .o_txd     (txd),
    .o_tx_busy (busy),
    .o_tx_done (done)
  );

  always #5 clk = ~clk;

  // Baud tick: one clock in 16, or stuck high; changes 2 ns after posedge.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (stuck) baud_en = 1'b1;
      else begin
        bcnt    = (bcnt == 15) ? 0 : bcnt + 1;
        baud_en = (bcnt == 15);
      end
    end
  end

  // Count cycles with TX_DONE high.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (done === 1'b1) done_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_bit(input logic [7:0] d, input int i);
    if (i == 0) return 1'b0;
    if (i <= DB) return d[i-1];
    if (PB == 1 && i == DB + 1) return ^d;
    return 1'b1;
  endfunction

  task automatic wait_fall(output int lat);
    lat = 0;
    while (txd !== 1'b0 && lat < LIMIT) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic wait_tick();
    int n = 0;
    while (baud_en !== 1'b1 && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    check("tick seen", 32'(n < LIMIT), 32'd1);
  endtask

  task automatic send(input logic [7:0] d);
    int n = 0;
    while (bus.tx_ready !== 1'b1 && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    check("send ready", 32'(n < LIMIT), 32'd1);
    bus.tx_data  = d;
    bus.tx_valid = 1'b1;
    @(negedge clk);
    bus.tx_valid = 1'b0;
  endtask

  // Called at the negedge where the start bit is first seen (k = 0).
  task automatic frame_body(input logic [7:0] d, input int per, input string tag);
    int errs  = 0;
    int first = -1;
    int d0    = done_cnt;
    for (int k = 0; k < NB * per; k++) begin
      if (txd !== exp_bit(d, k / per) || busy !== 1'b1 ||
          bus.tx_ready !== 1'b0 || done !== 1'b0) begin
        errs++;
        if (first < 0) first = k;
      end
      @(negedge clk);
    end
    check($sformatf("%s bits (first bad k=%0d)", tag, first), 32'(errs), 32'd0);
    check($sformatf("%s end {txd,done,busy,ready}", tag),
          32'({txd, done, busy, bus.tx_ready}), 32'b1101);
    check($sformatf("%s done pulses", tag), 32'(done_cnt - d0), 32'd1);
  endtask

  initial begin
    int lat;
    int d0;
    bus.tx_data  = '0;
    bus.tx_valid = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset {txd,ready,busy,done}", 32'({txd, bus.tx_ready, busy, done}), 32'b1100);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Basic frame 0x55
    send(8'h55);
    check("basic accepted busy", 32'(busy), 32'd1);
    wait_fall(lat);
    check("basic start latency", 32'(lat >= 1 && lat <= 16), 32'd1);
    frame_body(8'h55, 16, "basic");

    // Back-to-back 0xA3 then 0x0F with TX_VALID held high
    d0 = done_cnt;
    @(negedge clk);
    bus.tx_data  = 8'hA3;
    bus.tx_valid = 1'b1;
    @(negedge clk);
    bus.tx_data  = 8'h0F;
    wait_fall(lat);
    frame_body(8'hA3, 16, "b2b first");
    @(negedge clk);
    check("b2b second accepted", 32'({bus.tx_ready, busy}), 32'b01);
    bus.tx_valid = 1'b0;
    wait_fall(lat);
    check("b2b gap before start", 32'(lat), 32'd15);
    frame_body(8'h0F, 16, "b2b second");
    check("b2b total done pulses", 32'(done_cnt - d0), 32'd2);

    // Ignored input while busy with 0xFF
    wait_tick();
    @(negedge clk);
    bus.tx_data  = 8'hFF;
    bus.tx_valid = 1'b1;
    d0 = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.tx_ready !== 1'b0) d0++;
      bus.tx_data  = 8'h00;
      bus.tx_valid = ~bus.tx_valid;
    end
    bus.tx_valid = 1'b0;
    check("ignored ready low", 32'(d0), 32'd0);
    wait_fall(lat);
    frame_body(8'hFF, 16, "ignored");

    // Coincident tick and transfer: start bit waits for the next tick
    wait_tick();
    bus.tx_data  = 8'hC5;
    bus.tx_valid = 1'b1;
    @(negedge clk);
    bus.tx_valid = 1'b0;
    wait_fall(lat);
    check("coincident start latency", 32'(lat), 32'd16);
    frame_body(8'hC5, 16, "coincident");

    // Reset during data bit 3 of 0x00
    wait_tick();
    @(negedge clk);
    send(8'h00);
    wait_fall(lat);
    d0 = done_cnt;
    repeat (70) @(negedge clk);
    check("pre-reset data bit low", 32'(txd), 32'd0);
    #1 rst = 1'b1;
    #1 check("async reset {txd,busy,ready}", 32'({txd, busy, bus.tx_ready}), 32'b101);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post-reset ready", 32'(bus.tx_ready), 32'd1);
    check("no done after reset", 32'(done_cnt - d0), 32'd0);
    send(8'h81);
    wait_fall(lat);
    frame_body(8'h81, 16, "after reset");

    // BAUD_EN stuck high: one bit per clock (parity frames when enabled)
    stuck = 1'b1;
    repeat (2) @(negedge clk);
    send(8'h07);
    wait_fall(lat);
    check("fast start latency", 32'(lat), 32'd1);
    frame_body(8'h07, 1, "fast 0x07");
    send(8'h03);
    wait_fall(lat);
    check("fast start latency 2", 32'(lat), 32'd1);
    frame_body(8'h03, 1, "fast 0x03");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
